// File: rtl/ds_slave_byte.sv
// 1-Wire slave byte engine: bus-reset detect + presence pulse, write-slot receive, read-slot transmit; DS_SLAVE_CRC_EN adds a Dallas CRC8 over received bits.
// Latency: 2-flop input sync + 1-cycle edge detect; rx_vld/rst_det are registered, dq_oe is decoded from state.
// Backpressure: tx_vld/tx_rdy handshake, tx_rdy low while a byte is in flight; rx has none (rx_vld is a pulse).
module ds_slave_byte #(
    parameter int CLK_PER_US = 50,
    parameter int RST_US     = 400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       rst_det,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic [7:0] crc_out
);
    localparam int RST_CNT = RST_US * CLK_PER_US;
    localparam int CW      = $clog2(RST_CNT + 1);
    localparam logic [CW-1:0] T_SAMP  = CW'(30 * CLK_PER_US);
    localparam logic [CW-1:0] T_HOLD  = CW'(45 * CLK_PER_US);
    localparam logic [CW-1:0] T_PWAIT = CW'(30 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_PDRV  = CW'(120 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_RST   = CW'(RST_CNT);

    typedef enum logic [2:0] {IDLE, LOW, PRES_WAIT, PRES_DRV, REL} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rd_mode_q, rd_mode_d, samp_q, samp_d;
    logic [2:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d;
    logic          rx_vld_q, rx_vld_d, tx_ld_q, tx_ld_d, rst_det_q, rst_det_d;
    logic          dq_s, fall, rst_hit, slot_end, wbit, accept;

    assign dq_s     = sync2_q;
    assign fall     = prev_q & ~sync2_q;
    assign rst_hit  = (state_q == LOW) && !dq_s && (cnt_q == T_RST);
    assign slot_end = (state_q == LOW) && dq_s && ((cnt_q >= T_HOLD) || !dq_oe);
    // A write-1 slot ends before the sample point; the bus is already high then.
    assign wbit     = (cnt_q > T_SAMP) ? samp_q : dq_s;
    assign accept   = tx_vld && tx_rdy;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (fall) state_d = LOW;
            LOW: begin
                if (rst_hit)       state_d = PRES_WAIT;
                else if (slot_end) state_d = REL;
            end
            PRES_WAIT: if (dq_s && cnt_q == T_PWAIT) state_d = PRES_DRV;
            PRES_DRV:  if (cnt_q == T_PDRV) state_d = REL;
            REL:       if (dq_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        dq_oe  = 1'b0;
        tx_rdy = 1'b0;
        case (state_q)
            LOW:      dq_oe = rd_mode_q && !tx_sh_q[0] && (cnt_q < T_HOLD);
            PRES_DRV: dq_oe = 1'b1;
            IDLE:     tx_rdy = !tx_ld_q && (rx_cnt_q == 3'd0);
            default:  ;
        endcase
    end

    always_comb begin
        sync1_d   = dq_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        case (state_q)
            LOW:       cnt_d = rst_hit ? '0 : cnt_inc;
            PRES_WAIT: cnt_d = (!dq_s || cnt_q == T_PWAIT) ? '0 : cnt_inc;
            PRES_DRV:  cnt_d = (cnt_q == T_PDRV) ? '0 : cnt_inc;
            default:   cnt_d = '0;
        endcase
        // Slot mode is frozen at the falling edge, so a byte accepted in that same cycle waits one slot.
        rd_mode_d = (state_q == IDLE && fall) ? tx_ld_q : rd_mode_q;
        samp_d    = (state_q == LOW && cnt_q == T_SAMP) ? dq_s : samp_q;
        rx_cnt_d  = rx_cnt_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        tx_cnt_d  = tx_cnt_q;
        tx_sh_d   = tx_sh_q;
        tx_ld_d   = tx_ld_q;
        rst_det_d = 1'b0;
        if (accept) begin
            tx_ld_d  = 1'b1;
            tx_sh_d  = tx_data;
            tx_cnt_d = 3'd0;
        end
        if (slot_end && rd_mode_q) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd7) tx_ld_d = 1'b0;
        end
        if (slot_end && !rd_mode_q) begin
            rx_sh_d  = {wbit, rx_sh_q[7:1]};
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
                rx_data_d = {wbit, rx_sh_q[7:1]};
                rx_vld_d  = 1'b1;
            end
        end
        if (rst_hit) begin
            rst_det_d = 1'b1;
            rx_cnt_d  = 3'd0;
            rx_sh_d   = 8'h00;
            tx_ld_d   = 1'b0;
            tx_cnt_d  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            rd_mode_q <= 1'b0;
            samp_q    <= 1'b0;
            rx_cnt_q  <= 3'd0;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rx_vld_q  <= 1'b0;
            tx_cnt_q  <= 3'd0;
            tx_sh_q   <= 8'h00;
            tx_ld_q   <= 1'b0;
            rst_det_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            rd_mode_q <= rd_mode_d;
            samp_q    <= samp_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_sh_q   <= tx_sh_d;
            tx_ld_q   <= tx_ld_d;
            rst_det_q <= rst_det_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign rst_det = rst_det_q;

`ifdef DS_SLAVE_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_fb;

    assign crc_fb = crc_q[0] ^ wbit;

    always_comb begin
        crc_d = crc_q;
        if (rst_hit) begin
            crc_d = 8'h00;
        end else if (slot_end && !rd_mode_q) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;
`else
    assign crc_out = 8'h00;
`endif
endmodule
